// File: rtl/datapath.sv
// datapath: accumulator CPU datapath with acc, Z/N flags, add/sub ALU, operand muxes and data memory (in: clock_in, reset_in, operand_in, sel_A_in, sel_B_in, alu_op_in, data_memory_wr_in, acc_wr_in, status_wr_in, acc_reset_in, status_reset_in; out: acc_out, status_Z_out, status_N_out)
module datapath #(
  parameter int DATA_WIDTH = 16,
  parameter int OPERAND_WIDTH = 11,
  parameter int DATA_DEPTH = 2048
) (
  input  logic                     clock_in,
  input  logic                     reset_in,
  input  logic [OPERAND_WIDTH-1:0] operand_in,
  input  logic [1:0]               sel_A_in,
  input  logic                     sel_B_in,
  input  logic                     alu_op_in,
  input  logic                     data_memory_wr_in,
  input  logic                     acc_wr_in,
  input  logic                     status_wr_in,
  input  logic                     acc_reset_in,
  input  logic                     status_reset_in,
  output logic [DATA_WIDTH-1:0]    acc_out,
  output logic                     status_Z_out,
  output logic                     status_N_out
);
  localparam int AW = $clog2(DATA_DEPTH);
  logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];
  logic [AW-1:0] addr;
  logic [DATA_WIDTH-1:0] imm, mem_rd, b, alu, mux;
  assign addr = operand_in[AW-1:0];
  assign imm = {{(DATA_WIDTH-OPERAND_WIDTH){operand_in[OPERAND_WIDTH-1]}}, operand_in};
  assign mem_rd = mem[addr];
  always_comb begin
    b = sel_B_in ? imm : mem_rd;
    alu = alu_op_in ? acc_out - b : acc_out + b;
    mux = sel_A_in[1] ? (sel_A_in[0] ? '0 : alu) : (sel_A_in[0] ? imm : mem_rd);
  end
  always_ff @(posedge clock_in)
    if (data_memory_wr_in) mem[addr] <= acc_out;
  always_ff @(posedge clock_in)
    if (reset_in || acc_reset_in) acc_out <= '0;
    else if (acc_wr_in) acc_out <= mux;
  always_ff @(posedge clock_in)
    if (reset_in || status_reset_in) begin
      status_Z_out <= 1'b0;
      status_N_out <= 1'b0;
    end else if (status_wr_in) begin
      status_Z_out <= (mux == '0);
      status_N_out <= mux[DATA_WIDTH-1];
    end
endmodule

// File: tb/tb_datapath.sv
// tb_datapath: scoreboard bench for datapath driven by directed vectors with hand-computed expectations
module tb_datapath;
  logic clk = 1'b0;
  logic reset_in = 1'b0;
  logic [10:0] operand_in = '0;
  logic [1:0] sel_A_in = '0;
  logic sel_B_in = 1'b0;
  logic alu_op_in = 1'b0;
  logic data_memory_wr_in = 1'b0;
  logic acc_wr_in = 1'b0;
  logic status_wr_in = 1'b0;
  logic acc_reset_in = 1'b0;
  logic status_reset_in = 1'b0;
  logic [15:0] acc_out;
  logic status_Z_out, status_N_out;
  typedef struct {
    string name;
    logic [15:0] acc;
    logic z;
    logic n;
  } exp_t;
  exp_t q[$];
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  datapath dut (
    .clock_in(clk),
    .reset_in(reset_in),
    .operand_in(operand_in),
    .sel_A_in(sel_A_in),
    .sel_B_in(sel_B_in),
    .alu_op_in(alu_op_in),
    .data_memory_wr_in(data_memory_wr_in),
    .acc_wr_in(acc_wr_in),
    .status_wr_in(status_wr_in),
    .acc_reset_in(acc_reset_in),
    .status_reset_in(status_reset_in),
    .acc_out(acc_out),
    .status_Z_out(status_Z_out),
    .status_N_out(status_N_out)
  );
  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      total++;
      if (acc_out === e.acc && status_Z_out === e.z && status_N_out === e.n) passed++;
      else $display("FAIL %s: got acc=%h Z=%b N=%b, expected acc=%h Z=%b N=%b",
                    e.name, acc_out, status_Z_out, status_N_out, e.acc, e.z, e.n);
    end
  end
  task automatic step(input string name, input logic rst, input logic [10:0] op,
                      input logic [1:0] sa, input logic sb, input logic aop,
                      input logic dmw, input logic aw, input logic sw,
                      input logic ar, input logic sr,
                      input logic [15:0] e_acc, input logic e_z, input logic e_n);
    exp_t e;
    @(negedge clk);
    reset_in = rst;
    operand_in = op;
    sel_A_in = sa;
    sel_B_in = sb;
    alu_op_in = aop;
    data_memory_wr_in = dmw;
    acc_wr_in = aw;
    status_wr_in = sw;
    acc_reset_in = ar;
    status_reset_in = sr;
    @(posedge clk);
    #1;
    e.name = name;
    e.acc = e_acc;
    e.z = e_z;
    e.n = e_n;
    q.push_back(e);
  endtask
  initial begin
    //    name          rst op      sA    sB aop dmw aw sw ar sr  acc       Z  N
    step("reset",       1, 11'd5,   2'b01, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 0, 0);
    step("ld_imm_neg",  0, 11'h7FF, 2'b01, 0, 0, 0, 1, 1, 0, 0, 16'hFFFF, 0, 1);
    step("st_m3",       0, 11'd3,   2'b00, 0, 0, 1, 0, 0, 0, 0, 16'hFFFF, 0, 1);
    step("ld_imm_1",    0, 11'd1,   2'b01, 0, 0, 0, 1, 1, 0, 0, 16'h0001, 0, 0);
    step("add_wrap",    0, 11'd3,   2'b10, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 0);
    step("sub_under",   0, 11'd1,   2'b10, 1, 1, 0, 1, 1, 0, 0, 16'hFFFF, 0, 1);
    step("ld_42",       0, 11'h042, 2'b01, 0, 0, 0, 1, 1, 0, 0, 16'h0042, 0, 0);
    step("st_m9",       0, 11'd9,   2'b00, 0, 0, 1, 0, 0, 0, 0, 16'h0042, 0, 0);
    step("ld_234",      0, 11'h234, 2'b01, 0, 0, 0, 1, 1, 0, 0, 16'h0234, 0, 0);
    step("sub_neg1",    0, 11'h400, 2'b10, 1, 1, 0, 1, 1, 0, 0, 16'h0634, 0, 0);
    step("sub_neg2",    0, 11'h400, 2'b10, 1, 1, 0, 1, 1, 0, 0, 16'h0A34, 0, 0);
    step("sub_neg3",    0, 11'h400, 2'b10, 1, 1, 0, 1, 1, 0, 0, 16'h0E34, 0, 0);
    step("sub_neg4",    0, 11'h400, 2'b10, 1, 1, 0, 1, 1, 0, 0, 16'h1234, 0, 0);
    step("st_ld_same",  0, 11'd9,   2'b00, 0, 0, 1, 1, 0, 0, 0, 16'h0042, 0, 0);
    step("rd_m9_new",   0, 11'd9,   2'b00, 0, 0, 0, 1, 1, 0, 0, 16'h1234, 0, 0);
    step("acc_rst_pri", 0, 11'h7FF, 2'b01, 0, 0, 0, 1, 1, 1, 0, 16'h0000, 0, 1);
    step("st_rst_pri",  0, 11'h7FF, 2'b01, 0, 0, 0, 1, 1, 0, 1, 16'hFFFF, 0, 0);
    step("flag_no_acc", 0, 11'd0,   2'b11, 0, 0, 0, 0, 1, 0, 0, 16'hFFFF, 1, 0);
    step("flag_hold",   0, 11'h010, 2'b01, 0, 0, 0, 1, 0, 0, 0, 16'h0010, 1, 0);
    step("rst_mem_wr",  1, 11'd20,  2'b01, 0, 0, 1, 1, 1, 0, 0, 16'h0000, 0, 0);
    step("rd_m20",      0, 11'd20,  2'b00, 0, 0, 0, 1, 1, 0, 0, 16'h0010, 0, 0);
    step("sel_zero",    0, 11'd7,   2'b11, 0, 0, 0, 1, 1, 0, 0, 16'h0000, 1, 0);
    @(negedge clk);
    acc_wr_in = 1'b0;
    status_wr_in = 1'b0;
    data_memory_wr_in = 1'b0;
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/datapath.md
Name: datapath

Overview:
- Execution datapath of the accumulator CPU; sits directly downstream of the control unit and consumes its control strobes and 11-bit operand.
- Holds the accumulator, the Z/N status register, the add/sub ALU, the operand/memory muxes and the internal data memory.
- Returns status_Z_out/status_N_out to the control unit for branch decisions.

Parameters:
- DATA_WIDTH, 16, accumulator/ALU/memory word width.
- OPERAND_WIDTH, 11, width of operand_in; also data-memory address width.
- DATA_DEPTH, 2048, data-memory words; address = operand_in mod DATA_DEPTH, using the low log2(DATA_DEPTH) bits.

Ports:
- clock_in  input  1  single clock, rising edge.
- reset_in  input  1  synchronous, active-high, global reset.
- operand_in  input  OPERAND_WIDTH  immediate value / data-memory address.
- sel_A_in  input  2  accumulator source select.
- sel_B_in  input  1  ALU B operand select: 0 = memory word, 1 = sign-extended operand.
- alu_op_in  input  1  0 = add, 1 = subtract (acc - B).
- data_memory_wr_in  input  1  write accumulator to mem[operand_in].
- acc_wr_in  input  1  load accumulator.
- status_wr_in  input  1  load Z/N flags.
- acc_reset_in  input  1  synchronous accumulator clear.
- status_reset_in  input  1  synchronous flag clear.
- acc_out  output  DATA_WIDTH  accumulator contents.
- status_Z_out  output  1  registered zero flag.
- status_N_out  output  1  registered negative flag.

Behaviour:
- Sign extension: imm = operand_in[OPERAND_WIDTH-1] replicated to DATA_WIDTH.
- Memory read: combinational, mem_rd = mem[addr] in the same cycle.
- Memory write: on the rising edge when data_memory_wr_in=1, mem[addr] <= acc (pre-edge value). Not affected by any reset; contents are undefined until written.
- B operand: sel_B_in ? imm : mem_rd.
- ALU result: acc + B or acc - B, modulo 2^DATA_WIDTH. No carry or overflow flag.
- Accumulator source mux (sel_A_in):
  - 00 = mem_rd
  - 01 = imm
  - 10 = ALU result
  - 11 = zero
- Accumulator register, priority per edge:
  - reset_in → 0
  - else acc_reset_in → 0
  - else acc_wr_in → mux value
  - else hold
- Status register, priority per edge:
  - reset_in → Z=0, N=0
  - else status_reset_in → Z=0, N=0
  - else status_wr_in → Z = (mux value == 0), N = mux value[DATA_WIDTH-1]
  - else hold
- Flags are always computed from the sel_A mux value, independent of acc_wr_in.
- Latency: acc_out and flags update one edge after the strobe; outputs are purely registered.
- Reset values: acc_out=0, status_Z_out=0, status_N_out=0.
- Simultaneous data_memory_wr_in and acc_wr_in: memory stores the old acc; acc takes the new value in the same edge.
- Write and read of the same address in one cycle: the read returns the old word; the new word is visible from the next cycle.
- Reset mid-sequence: a pending memory write still commits if its strobe is high during the reset edge; acc and flags clear.
- Subtraction underflow wraps: 0 - 1 = 0xFFFF, so N=1, Z=0.

Test Plan:
- Reset: assert reset_in one cycle with acc_wr_in=1, sel_A_in=01, operand_in=5 → acc_out=0, Z=0, N=0.
- Load immediate and store:
  - sel_A_in=01, operand_in=0x7FF (sign bit set), acc_wr_in=1, status_wr_in=1 → acc_out=0xFFFF, N=1, Z=0.
  - Then data_memory_wr_in=1, operand_in=3 → mem[3]=0xFFFF.
- Memory add wrap: acc=0x0001, mem[3]=0xFFFF, sel_B_in=0, alu_op_in=0, sel_A_in=10, acc_wr_in=1, status_wr_in=1, operand_in=3 → acc_out=0x0000, Z=1, N=0.
- Subtract underflow: acc=0, sel_B_in=1, operand_in=1, alu_op_in=1, sel_A_in=10, acc_wr_in=1, status_wr_in=1 → acc_out=0xFFFF, N=1, Z=0.
- Simultaneous store and load:
  - acc=0x1234, data_memory_wr_in=1, acc_wr_in=1, sel_A_in=00, operand_in=9 (mem[9]=0x0042) → mem[9]=0x1234, acc_out=0x0042.
  - Next-cycle read of addr 9 → 0x1234.
- Priority:
  - acc_reset_in=1 with acc_wr_in=1 → acc_out=0.
  - status_reset_in=1 with status_wr_in=1 → Z=0, N=0.
  - Flags hold when status_wr_in=0 while acc changes.
